// File: rtl/tanh_divider_if.sv
// Operand/result bundle for the tanh divider: start plus sinh/cosh operands in,
// and the registered quotient with its status flags out.
interface tanh_divider_if #(
  parameter int WIDTH = 15
);
  logic             start;
  logic [WIDTH:0]   sinh_in;
  logic [WIDTH:0]   cosh_in;
  logic [WIDTH:0]   tanh_out;
  logic             valid;
  logic             busy;
  logic             err;

  modport master (
    output start, sinh_in, cosh_in,
    input  tanh_out, valid, busy, err
  );

  modport slave (
    input  start, sinh_in, cosh_in,
    output tanh_out, valid, busy, err
  );
endinterface

// File: rtl/tanh_divider.sv
// Fixed-point tanh = sinh/cosh using linear-vectoring CORDIC division,
// one iteration per clock, with a rising-edge start and a saturated registered result.
module tanh_divider #(
  parameter int WIDTH = 15,
  parameter int FRAC  = 12,
  parameter int ITERS = FRAC + 1
) (
  input  logic          clk,
  input  logic          reset,
  tanh_divider_if.slave bus
);
  localparam int IW = WIDTH + 3;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0]        LAST  = CW'(ITERS - 1);
  localparam logic signed [IW-1:0] Z_ONE = IW'(1) << FRAC;
  localparam logic signed [IW-1:0] Z_NEG = -Z_ONE;
  localparam logic [WIDTH:0]       O_ONE = (WIDTH + 1)'(1) << FRAC;
  localparam logic [WIDTH:0]       O_NEG = -O_ONE;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                state, state_nxt;
  logic                  start_q;
  logic                  trigger;
  logic                  cosh_bad;
  logic [CW-1:0]         i;
  logic signed [IW-1:0]  x, y, z;
  logic signed [IW-1:0]  x_sh, step, y_nxt, z_nxt;
  logic [WIDTH:0]        z_sat;

  assign trigger  = bus.start & ~start_q;
  assign cosh_bad = bus.cosh_in[WIDTH] | (bus.cosh_in == '0);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = cosh_bad ? DONE : ITER;
      ITER:    if (i == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One vectoring step: drive y toward zero, accumulating the quotient in z.
  always_comb begin
    x_sh = x >>> i;
    step = Z_ONE >>> i;
    if (!y[IW-1]) begin
      y_nxt = y - x_sh;
      z_nxt = z + step;
    end else begin
      y_nxt = y + x_sh;
      z_nxt = z - step;
    end
    if (z_nxt > Z_ONE)      z_sat = O_ONE;
    else if (z_nxt < Z_NEG) z_sat = O_NEG;
    else                    z_sat = z_nxt[WIDTH:0];
  end

  // Results are loaded on the edge entering DONE so valid and tanh_out
  // are presented together during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= 1'b0;
      i            <= '0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      bus.tanh_out <= '0;
      bus.valid    <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      start_q   <= bus.start;
      bus.valid <= 1'b0;
      case (state)
        IDLE: if (trigger) begin
          x <= {{2{bus.cosh_in[WIDTH]}}, bus.cosh_in};
          y <= {{2{bus.sinh_in[WIDTH]}}, bus.sinh_in};
          z <= '0;
          i <= '0;
        end
        ITER: begin
          y <= y_nxt;
          z <= z_nxt;
          i <= i + 1'b1;
        end
        default: ;
      endcase
      if (state_nxt == DONE) begin
        bus.valid    <= 1'b1;
        bus.err      <= (state == IDLE);
        bus.tanh_out <= (state == IDLE) ? '0 : z_sat;
      end
    end
  end
endmodule

// File: doc/tanh_divider.md
TANH_DIVIDER -- requirements
Module: tanh_divider

Interface
REQ-001 Parameter WIDTH, default 15: data words are WIDTH+1 bits, signed two's complement.
REQ-002 Parameter FRAC, default 12: fractional bits of every data word (1.0 = 4096 at default).
REQ-003 Parameter ITERS, default FRAC+1: number of CORDIC iterations (shift index i = 0 .. ITERS-1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  operation request from the upstream hyperbolic stage; only its rising edge is acted on.
REQ-007 sinh_in  input  WIDTH+1  sinh(z) operand (numerator).
REQ-008 cosh_in  input  WIDTH+1  cosh(z) operand (denominator).
REQ-009 tanh_out  output  WIDTH+1  registered quotient sinh_in/cosh_in, same fixed-point format.
REQ-010 valid  output  1  one-cycle pulse marking tanh_out/err as new.
REQ-011 busy  output  1  high while an operation is in progress (states ITER, DONE).
REQ-012 err  output  1  set with valid when cosh_in <= 0 was captured.

Function
REQ-013 The block SHALL register start every cycle as start_q and form trigger = start & ~start_q.
REQ-014 The FSM SHALL have states IDLE, ITER, DONE.
REQ-015 In IDLE on trigger, the block SHALL capture operands: x = cosh_in, y = sinh_in (sign-extended to WIDTH+3 bits), z = 0, i = 0.
REQ-016 If the captured cosh_in <= 0, the FSM SHALL go IDLE -> DONE with z = 0 and err_next = 1; otherwise IDLE -> ITER with err_next = 0.
REQ-017 Each ITER cycle (linear vectoring): if y >= 0, then y -= x>>>i and z += 2^(FRAC-i); else y += x>>>i and z -= 2^(FRAC-i). Then i += 1.
REQ-018 ITER SHALL last exactly ITERS cycles, then go to DONE.
REQ-019 In DONE (one cycle), the block SHALL set valid = 1 and go to IDLE.
REQ-020 In DONE, the block SHALL load tanh_out = z saturated to [-2^FRAC, +2^FRAC] and load err = err_next.
REQ-021 tanh_out and err SHALL hold their values until the next DONE.
REQ-022 Latency: for a trigger at cycle T, valid SHALL be high at cycle T+ITERS+1 (T+1 on the err path).
REQ-023 Internal x, y and z SHALL be WIDTH+3 bits wide so that no intermediate value overflows.
REQ-024 Accuracy: for 0 < cosh_in and |sinh_in| <= cosh_in, the result SHALL be within ±2 LSB of the true quotient.
REQ-025 A trigger while busy SHALL be ignored; operands SHALL not change mid-operation.
REQ-026 start held high SHALL produce exactly one operation; a new operation needs start to go low, then high.
REQ-027 start rising in the same cycle that DONE is active SHALL be ignored (the FSM is not in IDLE).

Reset
REQ-028 When reset = 1 at a clock edge: state = IDLE, tanh_out = 0, valid = 0, busy = 0, err = 0, start_q = 0, i = 0, x = y = z = 0.
REQ-029 Reset SHALL take priority over every other event, including mid-ITER and DONE; an aborted operation SHALL produce no valid pulse.
REQ-030 If start is high on the first cycle after reset is released, this SHALL count as a rising edge.

Verification
REQ-031 Basic case: sinh_in = 2134, cosh_in = 4619 (z = 0.5), pulse start -> valid exactly 14 cycles later, tanh_out = 1893 ±2, err = 0, busy high for cycles 1-14.
REQ-032 Sign and zero cases:
- sinh_in = -2134, cosh_in = 4619 -> tanh_out = -1893 ±2.
- sinh_in = 0, cosh_in = 4096 -> tanh_out = 0 ±1.
REQ-033 Error and saturation cases:
- cosh_in = 0, sinh_in = 100 -> valid at T+1, tanh_out = 0, err = 1, busy low at T+2.
- sinh_in = 8192, cosh_in = 4096 -> tanh_out = 4096, err = 0.
REQ-034 Trigger filtering: hold start high for 40 cycles -> exactly one valid pulse; a second rising edge during ITER -> ignored, no extra valid.
REQ-035 Reset and back-to-back:
- Assert reset at ITER cycle 5 -> no valid, all outputs zero; the next start completes normally.
- Two starts separated by 16 cycles -> two valid pulses with correct results.
